// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU result path: captured record layout,
// multiply command codes and the classification used by the latency tracker.
package alu_pkg;

  localparam logic [3:0] CMD_MUL_INC = 4'd9;
  localparam logic [3:0] CMD_MUL_SHL = 4'd10;

  typedef struct packed {
    logic err;
    logic oflow;
    logic cout;
    logic g;
    logic l;
    logic e;
  } alu_flags_t;

  typedef struct packed {
    logic [15:0] res;
    alu_flags_t  flags;
    logic [3:0]  cmd;
    logic        mode;
  } alu_rec_t;

  // One tracker stage: which command is in flight
  typedef struct packed {
    logic       vld;
    logic [3:0] cmd;
    logic       mode;
  } trk_t;

  // Arithmetic multiplies take the ALU's two-cycle result path
  function automatic logic is_mul(input logic mode, input logic [3:0] cmd);
    return mode && ((cmd == CMD_MUL_INC) || (cmd == CMD_MUL_SHL));
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Synchronous record FIFO; head is read combinationally and reads as zero when empty.
// A push while full is ignored unless the same edge also pops.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  alu_rec_t rec_i,
  input  logic     pop_i,
  output alu_rec_t rec_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  alu_rec_t       mem_q [DEPTH];
  logic [AW:0]    wr_q, wr_d;
  logic [AW:0]    rd_q, rd_d;
  logic           do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rec_o   = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + PTR_ONE;
    if (do_pop)  rd_d = rd_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= rec_i;
  end

endmodule

// File: rtl/alu_result_collector.sv
// Tracks ALU operations through their 1- or 2-cycle latency, captures res/flags
// at the completing edge and queues tagged records for a valid/ready consumer.
module alu_result_collector
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             mode,
  input  logic [3:0]       cmd,
  input  logic [1:0]       inp_valid,
  input  logic [15:0]      res,
  input  logic             err,
  input  logic             oflow,
  input  logic             cout,
  input  logic             g,
  input  logic             l,
  input  logic             e,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_res,
  output logic [5:0]       out_flags,
  output logic [3:0]       out_cmd,
  output logic             out_mode,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [1:0]       pending
);

  trk_t             s0_q, s0_d;
  trk_t             s1_q, s1_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             issue, s0_mul, cap_s0, cap_s1, capture, collide, ovf, pop;
  logic             fifo_full, fifo_empty;
  logic [1:0]       drop_inc;
  logic [CNT_W:0]   drop_sum;
  alu_rec_t         cap_rec, head;

  assign issue  = ce && (inp_valid != 2'b00);
  assign s0_mul = is_mul(s0_q.mode, s0_q.cmd);
  assign cap_s1 = ce && s1_q.vld;
  assign cap_s0 = ce && s0_q.vld && !s0_mul;
  assign capture = cap_s1 || cap_s0;
  // A finishing multiply owns the result bus; the single-cycle op is lost
  assign collide = cap_s1 && cap_s0;

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign ovf       = capture && fifo_full && !pop;

  always_comb begin
    cap_rec       = '0;
    cap_rec.res   = res;
    cap_rec.flags = '{err: err, oflow: oflow, cout: cout, g: g, l: l, e: e};
    cap_rec.cmd   = cap_s1 ? s1_q.cmd  : s0_q.cmd;
    cap_rec.mode  = cap_s1 ? s1_q.mode : s0_q.mode;
  end

  always_comb begin
    s0_d = s0_q;
    s1_d = s1_q;
    if (ce) begin
      s1_d = (s0_q.vld && s0_mul) ? s0_q : '0;
      s0_d = issue ? '{vld: 1'b1, cmd: cmd, mode: mode} : '0;
    end
  end

  // Collision and overflow can coincide, so the step may be 2; clamp at all-ones
  always_comb begin
    drop_inc = {1'b0, collide} + {1'b0, ovf};
    drop_sum = {1'b0, drop_q} + {{(CNT_W-1){1'b0}}, drop_inc};
    drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_q   <= '0;
      s1_q   <= '0;
      drop_q <= '0;
    end else begin
      s0_q   <= s0_d;
      s1_q   <= s1_d;
      drop_q <= drop_d;
    end
  end

  alu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (capture),
    .rec_i   (cap_rec),
    .pop_i   (pop),
    .rec_o   (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_res   = head.res;
  assign out_flags = head.flags;
  assign out_cmd   = head.cmd;
  assign out_mode  = head.mode;
  assign drop_cnt  = drop_q;
  assign pending   = {1'b0, s0_q.vld} + {1'b0, s1_q.vld};

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed bench: table of single-op vectors plus hand sequences for collision,
// overflow, ce stall and mid-flight reset.
module tb_alu_result_collector;

  logic        clk, rst, ce, mode, out_ready;
  logic [3:0]  cmd;
  logic [1:0]  inp_valid;
  logic [15:0] res;
  logic [5:0]  flg;
  logic        out_valid, out_mode;
  logic [15:0] out_res;
  logic [5:0]  out_flags;
  logic [3:0]  out_cmd;
  logic [7:0]  drop_cnt;
  logic [1:0]  pending;

  int n_chk = 0;
  int n_fail = 0;

  alu_result_collector #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ce(ce), .mode(mode), .cmd(cmd), .inp_valid(inp_valid),
    .res(res), .err(flg[5]), .oflow(flg[4]), .cout(flg[3]), .g(flg[2]), .l(flg[1]), .e(flg[0]),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_flags(out_flags),
    .out_cmd(out_cmd), .out_mode(out_mode), .drop_cnt(drop_cnt), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  iv;
    logic        mode;
    logic [3:0]  cmd;
    logic [15:0] res;
    logic [5:0]  flags;
    bit          exp_issue;
    bit          exp_mul;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; ce = 1'b0; inp_valid = 2'b00; out_ready = 1'b0;
    mode = 1'b0; cmd = 4'd0; res = 16'h0; flg = 6'h0;
    repeat (2) tick();
    rst = 1'b1;
    ce = 1'b1;
  endtask

  initial begin
    vecs[0] = '{2'b11, 1'b1, 4'd0,  16'h0013, 6'b000000, 1, 0};
    vecs[1] = '{2'b11, 1'b1, 4'd9,  16'h0C00, 6'b001000, 1, 1};
    vecs[2] = '{2'b01, 1'b1, 4'd10, 16'h01FE, 6'b010000, 1, 1};
    vecs[3] = '{2'b10, 1'b0, 4'd9,  16'h00F0, 6'b000100, 1, 0};
    vecs[4] = '{2'b11, 1'b1, 4'd11, 16'h0002, 6'b100001, 1, 0};
    vecs[5] = '{2'b00, 1'b1, 4'd0,  16'hFFFF, 6'b111111, 0, 0};
    vecs[6] = '{2'b11, 1'b0, 4'd15, 16'hFFFF, 6'b000011, 1, 0};

    do_reset();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_res",   32'(out_res),   0);
    chk("rst_flags", 32'(out_flags), 0);
    chk("rst_cmd",   32'(out_cmd),   0);
    chk("rst_mode",  32'(out_mode),  0);
    chk("rst_drop",  32'(drop_cnt),  0);
    chk("rst_pend",  32'(pending),   0);

    for (int i = 0; i < 7; i++) begin
      inp_valid = vecs[i].iv; mode = vecs[i].mode; cmd = vecs[i].cmd;
      res = 16'hDEAD; flg = 6'h2A;
      tick();
      inp_valid = 2'b00;
      chk($sformatf("v%0d_pend_issue", i), 32'(pending), vecs[i].exp_issue ? 1 : 0);
      chk($sformatf("v%0d_empty_issue", i), 32'(out_valid), 0);
      if (vecs[i].exp_mul) begin
        tick();
        chk($sformatf("v%0d_mul_no_rec", i), 32'(out_valid), 0);
        chk($sformatf("v%0d_mul_pend", i), 32'(pending), 1);
      end
      res = vecs[i].res; flg = vecs[i].flags;
      tick();
      res = 16'hDEAD; flg = 6'h2A;
      chk($sformatf("v%0d_valid", i), 32'(out_valid), vecs[i].exp_issue ? 1 : 0);
      chk($sformatf("v%0d_pend_done", i), 32'(pending), 0);
      if (vecs[i].exp_issue) begin
        chk($sformatf("v%0d_res", i),   32'(out_res),   32'(vecs[i].res));
        chk($sformatf("v%0d_flags", i), 32'(out_flags), 32'(vecs[i].flags));
        chk($sformatf("v%0d_cmd", i),   32'(out_cmd),   32'(vecs[i].cmd));
        chk($sformatf("v%0d_mode", i),  32'(out_mode),  32'(vecs[i].mode));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk($sformatf("v%0d_drained", i), 32'(out_valid), 0);
      end
    end
    chk("vec_drop", 32'(drop_cnt), 0);

    // Collision: mul then non-mul on consecutive edges
    do_reset();
    inp_valid = 2'b11; mode = 1'b1; cmd = 4'd9;
    tick();
    mode = 1'b0; cmd = 4'd1; res = 16'hAAAA;
    tick();
    inp_valid = 2'b00; res = 16'h1234; flg = 6'b000111;
    chk("col_pend2", 32'(pending), 2);
    tick();
    chk("col_valid", 32'(out_valid), 1);
    chk("col_res",   32'(out_res),   16'h1234);
    chk("col_cmd",   32'(out_cmd),   9);
    chk("col_mode",  32'(out_mode),  1);
    chk("col_drop",  32'(drop_cnt),  1);
    chk("col_pend0", 32'(pending),   0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("col_single", 32'(out_valid), 0);

    // Back-pressure overflow: five single-cycle ops into a 4-deep FIFO
    do_reset();
    for (int k = 0; k <= 5; k++) begin
      if (k < 5) begin
        inp_valid = 2'b01; mode = 1'b0; cmd = 4'(k + 1);
      end else begin
        inp_valid = 2'b00;
      end
      res = 16'h0100 + 16'(k - 1);
      tick();
    end
    chk("ovf_valid", 32'(out_valid), 1);
    chk("ovf_drop",  32'(drop_cnt),  1);
    chk("ovf_pend",  32'(pending),   0);
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("ovf_res%0d", j), 32'(out_res), 32'(16'h0100 + 16'(j)));
      chk($sformatf("ovf_cmd%0d", j), 32'(out_cmd), 32'(j + 1));
      tick();
    end
    out_ready = 1'b0;
    chk("ovf_empty", 32'(out_valid), 0);
    chk("ovf_drop_hold", 32'(drop_cnt), 1);

    // ce stall holds the tracker; inputs during the stall must not issue
    do_reset();
    inp_valid = 2'b11; mode = 1'b0; cmd = 4'd2;
    tick();
    ce = 1'b0; res = 16'hBEEF; cmd = 4'd3;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk($sformatf("ce_pend%0d", s), 32'(pending), 1);
      chk($sformatf("ce_nocap%0d", s), 32'(out_valid), 0);
    end
    ce = 1'b1; inp_valid = 2'b00; res = 16'h00C3;
    tick();
    chk("ce_valid", 32'(out_valid), 1);
    chk("ce_res",   32'(out_res),   16'h00C3);
    chk("ce_cmd",   32'(out_cmd),   2);
    chk("ce_pend",  32'(pending),   0);

    // Mid-flight reset with one buffered record and a mul in flight
    do_reset();
    inp_valid = 2'b11; mode = 1'b0; cmd = 4'd4;
    tick();
    mode = 1'b1; cmd = 4'd10; res = 16'h0055;
    tick();
    inp_valid = 2'b00;
    chk("mr_pre_valid", 32'(out_valid), 1);
    chk("mr_pre_pend",  32'(pending),   1);
    #2 rst = 1'b0;
    #1;
    chk("mr_valid", 32'(out_valid), 0);
    chk("mr_res",   32'(out_res),   0);
    chk("mr_cmd",   32'(out_cmd),   0);
    chk("mr_pend",  32'(pending),   0);
    chk("mr_drop",  32'(drop_cnt),  0);
    #1 rst = 1'b1;
    repeat (3) tick();
    chk("mr_post_valid", 32'(out_valid), 0);
    chk("mr_post_pend",  32'(pending),   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
